// File: rtl/fpu_issue.sv
// Issue side of the FPU unit handshake: launches one operation, waits for the
// unit's result pulse and holds it for register-file writeback.
module fpu_issue #(
  parameter int TIMEOUT = 16,
  parameter int RD_W    = 6
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [2:0]      req_op,
  input  logic [RD_W-1:0] req_rd,
  input  logic            req_bitres,
  input  logic            flush,
  output logic            data_valid,
  output logic [31:0]     a_data,
  output logic [31:0]     b_data,
  output logic [2:0]      op_data,
  input  logic [31:0]     c_data,
  input  logic            c_valid,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            busy,
  output logic            err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DRAIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       bitres;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] fmt_result(input logic bit_only, input logic [31:0] raw);
    return bit_only ? {31'b0, raw[0]} : raw;
  endfunction

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      bitres     <= 1'b0;
      req_ready  <= 1'b1;
      data_valid <= 1'b0;
      wb_valid   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      a_data     <= 32'd0;
      b_data     <= 32'd0;
      op_data    <= 3'd0;
      wb_data    <= 32'd0;
      wb_rd      <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (c_valid) err <= 1'b1;
          if (req_valid && req_ready && !flush) begin
            a_data     <= req_a;
            b_data     <= req_b;
            op_data    <= req_op;
            wb_rd      <= req_rd;
            bitres     <= req_bitres;
            data_valid <= 1'b1;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (c_valid) err <= 1'b1;
          cnt   <= 8'd0;
          state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          // A flush that coincides with the result has nothing left to drain.
          if (flush && c_valid) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (flush) begin
            cnt   <= 8'd0;
            state <= S_DRAIN;
          end else if (c_valid) begin
            wb_data  <= fmt_result(bitres, c_data);
            wb_valid <= 1'b1;
            state    <= S_WB;
          end else if (cnt == TO_LAST) begin
            cnt      <= sat_inc(cnt);
            wb_data  <= 32'd0;
            wb_valid <= 1'b1;
            err      <= 1'b1;
            state    <= S_WB;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_WB: begin
          if (c_valid) err <= 1'b1;
          if (flush || wb_ready) begin
            wb_valid  <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (c_valid || cnt == TO_LAST) begin
            if (!c_valid) err <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          wb_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with a behavioural two-cycle compare unit.
module tb_fpu_issue;

  localparam int RD_W = 6;

  logic            aclk = 1'b0;
  logic            areset;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [2:0]      req_op;
  logic [RD_W-1:0] req_rd;
  logic            req_bitres;
  logic            flush;
  logic            data_valid;
  logic [31:0]     a_data;
  logic [31:0]     b_data;
  logic [2:0]      op_data;
  logic [31:0]     c_data;
  logic            c_valid;
  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            busy;
  logic            err;

  int total = 0;
  int bad   = 0;

  // Compare-unit model: samples data_valid, answers two cycles later.
  logic        unit_en = 1'b1;
  logic        unit_s1 = 1'b0;
  logic        unit_c  = 1'b0;
  logic        man_c   = 1'b0;
  logic [31:0] unit_a  = 32'd0;
  logic [31:0] unit_b  = 32'd0;
  logic [2:0]  unit_op = 3'd0;
  logic [31:0] unit_res = 32'd0;

  assign c_valid = unit_c | man_c;
  assign c_data  = unit_res;

  always #5 aclk = ~aclk;

  fpu_issue #(.TIMEOUT(16), .RD_W(RD_W)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rd(req_rd),
    .req_bitres(req_bitres), .flush(flush),
    .data_valid(data_valid), .a_data(a_data), .b_data(b_data), .op_data(op_data),
    .c_data(c_data), .c_valid(c_valid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err(err)
  );

  function automatic logic fcmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    logic eq, lt;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    eq = (a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
    lt = !eq && (ka < kb);
    case (op)
      3'd0: return eq;
      3'd1: return !eq;
      3'd2: return lt || eq;
      3'd3: return !lt;
      3'd4: return lt;
      3'd5: return !lt && !eq;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge aclk) begin
    unit_c  <= unit_en && unit_s1;
    unit_s1 <= data_valid;
    if (data_valid) begin
      unit_a  <= a_data;
      unit_b  <= b_data;
      unit_op <= op_data;
    end
    if (unit_s1) unit_res <= {31'h1234_5678, fcmp(unit_op, unit_a, unit_b)};
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [RD_W-1:0] rd, input logic br);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd; req_bitres = br;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    tick; tick;
    areset = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if ({data_valid, wb_valid, busy, err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {data_valid, wb_valid, busy, err}); end
    total++; if ({a_data, b_data, op_data} !== 67'd0) begin bad++; $display("FAIL reset_operands got=%h want=0", {a_data, b_data, op_data}); end
    total++; if ({wb_data, wb_rd} !== 38'd0) begin bad++; $display("FAIL reset_wb got=%h want=0", {wb_data, wb_rd}); end
  endtask

  task automatic test_compare_lt;
    wb_ready = 1'b1;
    issue(3'd4, 32'hBF80_0000, 32'h3F80_0000, 6'd5, 1'b1);
    tick;
    req_valid = 1'b0;
    total++; if ({data_valid, busy, req_ready} !== 3'b110) begin bad++; $display("FAIL lt_issue got=%b want=110", {data_valid, busy, req_ready}); end
    total++; if (op_data !== 3'd4) begin bad++; $display("FAIL lt_op got=%0d want=4", op_data); end
    tick;
    total++; if ({data_valid, wb_valid} !== 2'b00) begin bad++; $display("FAIL lt_single_pulse got=%b want=00", {data_valid, wb_valid}); end
    tick;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lt_wb_early got=%b want=0", wb_valid); end
    tick;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL lt_wb_k4 got=%b want=1", wb_valid); end
    total++; if (wb_data !== 32'h1) begin bad++; $display("FAIL lt_wb_data got=%h want=00000001", wb_data); end
    total++; if (wb_rd !== 6'd5) begin bad++; $display("FAIL lt_wb_rd got=%0d want=5", wb_rd); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL lt_err got=%b want=0", err); end
    tick;
    total++; if ({req_ready, wb_valid, busy} !== 3'b100) begin bad++; $display("FAIL lt_idle_k5 got=%b want=100", {req_ready, wb_valid, busy}); end
  endtask

  task automatic test_full_word;
    wb_ready = 1'b1;
    issue(3'd5, 32'h3F80_0000, 32'hBF80_0000, 6'd9, 1'b0);
    tick;
    req_valid = 1'b0;
    tick; tick; tick;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL word_wb_valid got=%b want=1", wb_valid); end
    total++; if (wb_data !== 32'h2468_ACF1) begin bad++; $display("FAIL word_wb_data got=%h want=2468acf1", wb_data); end
    tick;
  endtask

  task automatic test_backpressure;
    int acc;
    acc = 0;
    wb_ready = 1'b0;
    issue(3'd0, 32'h4000_0000, 32'h4000_0000, 6'd7, 1'b1);
    tick;
    issue(3'd5, 32'h3F80_0000, 32'h4000_0000, 6'd3, 1'b1);
    tick; tick; tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wb_ready = 1'b1;
      total++;
      if ({wb_valid, req_ready, wb_data, wb_rd} !== {2'b10, 32'h1, 6'd7}) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b%b %h %0d want=10 00000001 7", i, wb_valid, req_ready, wb_data, wb_rd);
      end
      if (wb_valid && wb_ready) acc++;
      tick;
    end
    total++; if (acc !== 1) begin bad++; $display("FAIL bp_accepts got=%0d want=1", acc); end
    total++; if ({wb_valid, req_ready, busy} !== 3'b010) begin bad++; $display("FAIL bp_idle got=%b want=010", {wb_valid, req_ready, busy}); end
    tick;
    req_valid = 1'b0;
    total++; if ({data_valid, wb_rd} !== {1'b1, 6'd3}) begin bad++; $display("FAIL bp_second_issue got=%b %0d want=1 3", data_valid, wb_rd); end
    tick; tick; tick;
    total++; if ({wb_valid, wb_data} !== {1'b1, 32'h0}) begin bad++; $display("FAIL bp_second_wb got=%b %h want=1 00000000", wb_valid, wb_data); end
    tick;
  endtask

  task automatic test_flush;
    wb_ready = 1'b1;
    issue(3'd5, 32'hBF80_0000, 32'h3F80_0000, 6'd4, 1'b1);
    tick;
    req_valid = 1'b0;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++; if ({c_valid, busy, wb_valid} !== 3'b110) begin bad++; $display("FAIL flush_drain got=%b want=110", {c_valid, busy, wb_valid}); end
    tick;
    total++; if ({busy, req_ready, wb_valid, err} !== 4'b0100) begin bad++; $display("FAIL flush_idle got=%b want=0100", {busy, req_ready, wb_valid, err}); end
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 6'd6, 1'b1);
    tick;
    req_valid = 1'b0;
    tick; tick; tick;
    total++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h1, 6'd6}) begin bad++; $display("FAIL flush_next got=%b %h %0d want=1 00000001 6", wb_valid, wb_data, wb_rd); end
    tick;
  endtask

  task automatic test_flush_wb;
    wb_ready = 1'b0;
    issue(3'd4, 32'hBF80_0000, 32'h3F80_0000, 6'd8, 1'b1);
    tick;
    req_valid = 1'b0;
    tick; tick; tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++; if ({wb_valid, busy, req_ready} !== 3'b001) begin bad++; $display("FAIL flush_wb got=%b want=001", {wb_valid, busy, req_ready}); end
    wb_ready = 1'b1;
  endtask

  task automatic test_timeout;
    int wb_at;
    wb_at = -1;
    unit_en = 1'b0;
    wb_ready = 1'b1;
    issue(3'd0, 32'h0, 32'h0, 6'd2, 1'b1);
    tick;
    req_valid = 1'b0;
    for (int i = 1; i <= 24 && wb_at < 0; i++) begin
      tick;
      if (wb_valid) wb_at = i;
    end
    total++; if (wb_at !== 17) begin bad++; $display("FAIL to_latency got=%0d want=17", wb_at); end
    total++; if ({wb_data, err} !== {32'h0, 1'b1}) begin bad++; $display("FAIL to_result got=%h %b want=00000000 1", wb_data, err); end
    tick; tick; tick;
    total++; if ({err, req_ready} !== 2'b11) begin bad++; $display("FAIL to_sticky got=%b want=11", {err, req_ready}); end
    unit_en = 1'b1;
    areset = 1'b1;
    tick;
    areset = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b want=0", err); end
  endtask

  task automatic test_stray;
    man_c = 1'b1;
    tick;
    man_c = 1'b0;
    total++; if ({err, wb_valid, req_ready, busy} !== 4'b1010) begin bad++; $display("FAIL stray got=%b want=1010", {err, wb_valid, req_ready, busy}); end
  endtask

  task automatic test_reset_wait;
    unit_en = 1'b0;
    issue(3'd1, 32'h1, 32'h2, 6'd1, 1'b1);
    tick;
    req_valid = 1'b0;
    tick; tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rw_waiting got=%b want=1", busy); end
    areset = 1'b1;
    tick;
    areset = 1'b0;
    total++; if ({req_ready, busy, err, wb_valid} !== 4'b1000) begin bad++; $display("FAIL rw_reset got=%b want=1000", {req_ready, busy, err, wb_valid}); end
    man_c = 1'b1;
    tick;
    man_c = 1'b0;
    total++; if ({err, wb_valid} !== 2'b10) begin bad++; $display("FAIL rw_late_c got=%b want=10", {err, wb_valid}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; req_valid = 1'b0; req_a = 32'd0; req_b = 32'd0; req_op = 3'd0;
    req_rd = '0; req_bitres = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    #1;
    test_reset;
    test_compare_lt;
    test_full_word;
    test_backpressure;
    test_flush;
    test_flush_wb;
    test_timeout;
    test_stray;
    test_reset_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
